// File: rtl/fir_cmplx_pkg.sv
// fir_cmplx_pkg: sizes, Q10 channel coefficients, FSM states and the round-toward-zero tap arithmetic.
package fir_cmplx_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int NUM_TAPS = 20;
  localparam int FRAC_BITS = 10;
  localparam int FIFO_DEPTH = 16;
  typedef logic signed [DATA_WIDTH-1:0] smp_t;
  typedef logic [4:0] tap_t;
  localparam smp_t H_REAL [NUM_TAPS] = '{-12, -25, 0, 48, 90, 60, -40, -150, 210, 480,
                                        480, 210, -150, -40, 60, 90, 48, 0, -25, -12};
  localparam smp_t H_IMAG [NUM_TAPS] = '{5, -7, 12, -20, 30, -45, 60, -80, 100, -120,
                                        120, -100, 80, -60, 45, -30, 20, -12, 7, -5};
  typedef enum logic [1:0] {IDLE, MAC, WRITE} state_t;
  // Biasing negatives by 2^FRAC_BITS-1 before the shift makes it truncate toward zero.
  function automatic smp_t dequantize(input logic signed [63:0] p);
    return 32'((p + (p[63] ? (64'sd1 <<< FRAC_BITS) - 64'sd1 : 64'sd0)) >>> FRAC_BITS);
  endfunction
  function automatic smp_t tap_term(input smp_t h0, input smp_t h1, input smp_t a, input smp_t b);
    return dequantize(64'(h0) * 64'(a)) - dequantize(64'(h1) * 64'(b));
  endfunction
endpackage

// File: rtl/fir_cmplx_fifo.sv
// fifo: synchronous first-word-fall-through FIFO with occupancy count; head reads 0 while empty.
module fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           din,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic push, pop;
  always_comb begin
    push = wr_en && cnt_q != FULL;
    pop = rd_en && cnt_q != '0;
    mem_d = mem_q;
    if (push) mem_d[wr_q] = din;
    wr_d = wr_q + AW'(push);
    rd_d = rd_q + AW'(pop);
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) mem_q <= mem_d;
  assign empty = cnt_q == '0;
  assign dout = empty ? '0 : mem_q[rd_q];
  assign count = cnt_q;
endmodule

// File: rtl/fir_cmplx.sv
// fir_cmplx: complex 20-tap FIR between FWFT FIFOs; sequential single-MAC FSM by default,
// define FIR_CMPLX_PARALLEL_EN for the fully parallel 1 sample/cycle datapath.
module fir_cmplx import fir_cmplx_pkg::*; (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] i_in,
  input  logic [DATA_WIDTH-1:0] q_in,
  input  logic                  in_wr_en,
  output logic                  in_full,
  output logic [DATA_WIDTH-1:0] y_out_real,
  output logic [DATA_WIDTH-1:0] y_out_imag,
  input  logic                  out_rd_en,
  output logic                  out_empty
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  logic [2*DATA_WIDTH-1:0] in_dout, out_din, out_dout;
  logic [CW-1:0] in_cnt, out_cnt;
  logic in_empty, in_pop, out_push;
  smp_t xr_q [NUM_TAPS];
  smp_t xr_d [NUM_TAPS];
  smp_t xi_q [NUM_TAPS];
  smp_t xi_d [NUM_TAPS];
  fifo #(.WIDTH(2*DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_in_fifo (
    .clk(clock), .rst(reset), .wr_en(in_wr_en), .din({i_in, q_in}), .rd_en(in_pop),
    .dout(in_dout), .empty(in_empty), .count(in_cnt)
  );
  fifo #(.WIDTH(2*DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_out_fifo (
    .clk(clock), .rst(reset), .wr_en(out_push), .din(out_din), .rd_en(out_rd_en),
    .dout(out_dout), .empty(out_empty), .count(out_cnt)
  );
  assign in_full = in_cnt == FULL;
  assign y_out_real = out_dout[2*DATA_WIDTH-1:DATA_WIDTH];
  assign y_out_imag = out_dout[DATA_WIDTH-1:0];
  always_comb begin
    xr_d = xr_q;
    xi_d = xi_q;
    if (in_pop) begin
      xr_d[0] = in_dout[2*DATA_WIDTH-1:DATA_WIDTH];
      xi_d[0] = in_dout[DATA_WIDTH-1:0];
      for (int j = 1; j < NUM_TAPS; j++) begin
        xr_d[j] = xr_q[j-1];
        xi_d[j] = xi_q[j-1];
      end
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      xr_q <= '{default: '0};
      xi_q <= '{default: '0};
    end else begin
      xr_q <= xr_d;
      xi_q <= xi_d;
    end
  end
`ifdef FIR_CMPLX_PARALLEL_EN
  localparam int GROUPS = 4;
  localparam int GSZ = NUM_TAPS / GROUPS;
  logic [2:0] v_q, v_d;
  smp_t pr_q [GROUPS];
  smp_t pr_d [GROUPS];
  smp_t pi_q [GROUPS];
  smp_t pi_d [GROUPS];
  smp_t sr_q, sr_d, si_q, si_d;
  // Pop only if the output FIFO can absorb every sample already in the pipe.
  always_comb begin
    in_pop = !in_empty && int'(out_cnt) + $countones(v_q) < FIFO_DEPTH;
    v_d = {v_q[1:0], in_pop};
    for (int g = 0; g < GROUPS; g++) begin
      pr_d[g] = '0;
      pi_d[g] = '0;
      for (int j = 0; j < GSZ; j++) begin
        pr_d[g] = pr_d[g] + tap_term(H_REAL[g*GSZ+j], H_IMAG[g*GSZ+j], xr_q[g*GSZ+j], xi_q[g*GSZ+j]);
        pi_d[g] = pi_d[g] + tap_term(H_REAL[g*GSZ+j], H_IMAG[g*GSZ+j], xi_q[g*GSZ+j], xr_q[g*GSZ+j]);
      end
    end
    sr_d = pr_q[0] + pr_q[1] + pr_q[2] + pr_q[3];
    si_d = pi_q[0] + pi_q[1] + pi_q[2] + pi_q[3];
    out_push = v_q[2];
    out_din = {sr_q, si_q};
  end
  always_ff @(posedge clock) begin
    v_q <= reset ? '0 : v_d;
    pr_q <= pr_d;
    pi_q <= pi_d;
    sr_q <= sr_d;
    si_q <= si_d;
  end
`else
  localparam tap_t LAST = tap_t'(NUM_TAPS - 1);
  state_t state_q, state_d;
  tap_t k_q, k_d;
  smp_t acc_r_q, acc_r_d, acc_i_q, acc_i_d;
  always_comb begin
    in_pop = state_q == IDLE && !in_empty && out_cnt != FULL;
    out_push = state_q == WRITE;
    out_din = {acc_r_q, acc_i_q};
    state_d = (state_q == IDLE) ? (in_pop ? MAC : IDLE)
            : (state_q == MAC) ? (k_q == LAST ? WRITE : MAC) : IDLE;
    k_d = (state_q == MAC) ? k_q + tap_t'(1) : '0;
    acc_r_d = (state_q == IDLE) ? '0 : (state_q == MAC)
            ? acc_r_q + tap_term(H_REAL[k_q], H_IMAG[k_q], xr_q[k_q], xi_q[k_q]) : acc_r_q;
    acc_i_d = (state_q == IDLE) ? '0 : (state_q == MAC)
            ? acc_i_q + tap_term(H_REAL[k_q], H_IMAG[k_q], xi_q[k_q], xr_q[k_q]) : acc_i_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      k_q <= '0;
      acc_r_q <= '0;
      acc_i_q <= '0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      acc_r_q <= acc_r_d;
      acc_i_q <= acc_i_d;
    end
  end
`endif
endmodule

// File: tb/tb_fir_cmplx.sv
// tb_fir_cmplx: table vectors plus a scoreboard fed by a division-based reference of the complex FIR.
module tb_fir_cmplx;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [31:0] i_in = '0, q_in = '0;
  logic in_wr_en = 1'b0, out_rd_en = 1'b0;
  logic in_full, out_empty;
  logic [31:0] y_out_real, y_out_imag;

  fir_cmplx dut (
    .clock(clock), .reset(reset), .i_in(i_in), .q_in(q_in), .in_wr_en(in_wr_en),
    .in_full(in_full), .y_out_real(y_out_real), .y_out_imag(y_out_imag),
    .out_rd_en(out_rd_en), .out_empty(out_empty)
  );

  always #5 clock = ~clock;

  typedef struct {
    int i;
    int q;
    int er;
    int ei;
  } vec_t;

  int HR[20] = '{-12, -25, 0, 48, 90, 60, -40, -150, 210, 480,
                 480, 210, -150, -40, 60, 90, 48, 0, -25, -12};
  int HI[20] = '{5, -7, 12, -20, 30, -45, 60, -80, 100, -120,
                 120, -100, 80, -60, 45, -30, 20, -12, 7, -5};
  int n_chk = 0, n_pass = 0, n_acc = 0, n_pop = 0;
  int hr[20], hi[20];
  int sb_r[$], sb_i[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  // Reference: y = sum over taps of products divided by 1024 (SV division truncates toward zero).
  function automatic void model_accept(input int i, input int q);
    int yr, yi;
    for (int k = 19; k > 0; k--) begin
      hr[k] = hr[k-1];
      hi[k] = hi[k-1];
    end
    hr[0] = i;
    hi[0] = q;
    yr = 0;
    yi = 0;
    for (int k = 0; k < 20; k++) begin
      yr += int'(longint'(HR[k]) * hr[k] / 1024) - int'(longint'(HI[k]) * hi[k] / 1024);
      yi += int'(longint'(HR[k]) * hi[k] / 1024) - int'(longint'(HI[k]) * hr[k] / 1024);
    end
    sb_r.push_back(yr);
    sb_i.push_back(yi);
  endfunction

  always @(negedge clock) begin
    if (reset) begin
      sb_r.delete();
      sb_i.delete();
      for (int k = 0; k < 20; k++) begin
        hr[k] = 0;
        hi[k] = 0;
      end
    end else begin
      if (out_rd_en && !out_empty) begin
        if (sb_r.size() == 0) chk("unexpected_output", {y_out_real, y_out_imag}, 'x);
        else begin
          chk("stream", {y_out_real, y_out_imag}, {sb_r[0], sb_i[0]});
          void'(sb_r.pop_front());
          void'(sb_i.pop_front());
          n_pop++;
        end
      end
      if (in_wr_en && !in_full) begin
        model_accept(i_in, q_in);
        n_acc++;
      end
    end
  end

  task automatic wait_cycle;
    @(posedge clock);
    #1;
  endtask

  task automatic push(input int i, input int q);
    int b = 0;
    while (in_full && b < 3000) begin
      wait_cycle;
      b++;
    end
    if (in_full) chk("push_timeout", 1, 0);
    else begin
      i_in = i;
      q_in = q;
      in_wr_en = 1'b1;
      wait_cycle;
      in_wr_en = 1'b0;
    end
  endtask

  task automatic pop_one(output logic [63:0] v);
    int b = 0;
    while (out_empty && b < 200) begin
      wait_cycle;
      b++;
    end
    v = 'x;
    if (!out_empty) begin
      v = {y_out_real, y_out_imag};
      out_rd_en = 1'b1;
      wait_cycle;
      out_rd_en = 1'b0;
    end
  endtask

  task automatic rst_pulse;
    reset = 1'b1;
    wait_cycle;
    reset = 1'b0;
  endtask

  task automatic run_table(input vec_t t[20], input string tag);
    fork
      for (int j = 0; j < 20; j++) push(t[j].i, t[j].q);
      for (int j = 0; j < 20; j++) begin
        logic [63:0] v;
        pop_one(v);
        chk($sformatf("%s%0d", tag, j), v, {t[j].er, t[j].ei});
      end
    join
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t imp[20], tz[20];
    logic [63:0] v;
    int lat, a0, p0, b;
    for (int k = 0; k < 20; k++) begin
      imp[k] = '{(k == 0) ? 1024 : 0, 0, HR[k], -HI[k]};
      tz[k] = '{1, 0, 0, 0};
    end
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    chk("rst_out_empty", 64'(out_empty), 1);
    chk("rst_in_full", 64'(in_full), 0);
    chk("rst_y", {y_out_real, y_out_imag}, 0);

    push(5, 7);
    lat = 0;
    while (out_empty && lat < 100) begin
      wait_cycle;
      lat++;
    end
    chk("latency_within_24", 64'(lat <= 24), 1);
    pop_one(v);

    rst_pulse;
    run_table(imp, "impulse");
    run_table(tz, "toward_zero");

    a0 = n_acc;
    p0 = n_pop;
    fork
      for (int j = 0; j < 40; j++) push($urandom, $urandom);
      begin
        int w = 0;
        while (n_acc - a0 < 32 && w < 3000) begin
          wait_cycle;
          w++;
        end
        repeat (60) wait_cycle;
        chk("bp_in_full", 64'(in_full), 1);
        chk("bp_accepted", 64'(n_acc - a0), 32);
        chk("bp_out_empty", 64'(out_empty), 0);
        chk("bp_no_pop", 64'(n_pop - p0), 0);
        out_rd_en = 1'b1;
      end
    join
    b = 0;
    while (n_pop - p0 < 40 && b < 3000) begin
      wait_cycle;
      b++;
    end
    out_rd_en = 1'b0;
    chk("bp_drained", 64'(n_pop - p0), 40);

    for (int j = 0; j < 5; j++) push($urandom, $urandom);
    rst_pulse;
    chk("midrst_out_empty", 64'(out_empty), 1);
    chk("midrst_in_full", 64'(in_full), 0);
    chk("midrst_y", {y_out_real, y_out_imag}, 0);
    run_table(imp, "impulse_after_rst");

    p0 = n_pop;
    fork
      for (int j = 0; j < 100; j++) begin
        repeat ($urandom_range(0, 2)) wait_cycle;
        if (j % 2 == 0) push($urandom, $urandom);
        else push($urandom_range(0, 4095) - 2048, $urandom_range(0, 4095) - 2048);
      end
      begin
        int w = 0;
        while (n_pop - p0 < 100 && w < 8000) begin
          out_rd_en = 1'($urandom_range(0, 1));
          wait_cycle;
          w++;
        end
        out_rd_en = 1'b0;
      end
    join
    chk("rnd_count", 64'(n_pop - p0), 100);
    chk("scoreboard_empty", 64'(sb_r.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
